pipelined_addsub: RTL and testbench

- Parametrised successor to the 4-bit structural ripple adder.
- WIDTH-bit adder/subtractor, split into CHUNK-bit ripple slices, one pipeline register per slice; the carry crosses stage boundaries.
- Valid/ready streaming interface, one operation per cycle sustained.
- Flags: carry/no-borrow, signed overflow, zero. Used as the arithmetic core of the upcoming ALU datapath.

---
 rtl/pipelined_addsub_pkg.sv | 18 +
 rtl/addsub_chunk.sv | 31 +++
 rtl/full_adder.sv | 13 +
 rtl/pipelined_addsub.sv | 135 +++++++++++++
 tb/tb_pipelined_addsub.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: default geometry,
// stage-count derivation and the add/sub opcode encoding.
package pipelined_addsub_pkg;

  localparam int unsigned DefaultWidth = 16;
  localparam int unsigned DefaultChunk = 4;

  typedef enum logic {
    OpAdd = 1'b0,
    OpSub = 1'b1
  } op_e;

  // Pipeline depth equals the number of ripple slices.
  function automatic int unsigned calc_stages(input int unsigned width, input int unsigned chunk);
    return (chunk == 0) ? 1 : width / chunk;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// CHUNK-bit combinational ripple slice built from full_adder cells.
// c_msb_in is the carry into the slice MSB, used for signed overflow.
module addsub_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple slices.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_addsub.sv
// WIDTH-bit adder/subtractor pipelined as CHUNK-bit ripple slices with a
// valid/ready stream interface; the whole pipe advances or stalls together.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CHUNK = DefaultChunk
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned STAGES = calc_stages(WIDTH, CHUNK);

  if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic             adv;
  op_e              op;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign op    = op_e'(sub);
  assign b_eff = (op == OpSub) ? ~b : b;
  assign c0    = (op == OpSub) ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be consumed by this and later slices.
    localparam int unsigned WIn = WIDTH - k * CHUNK;

    logic [WIn-1:0]           a_in;
    logic [WIn-1:0]           b_in;
    logic                     c_in;
    logic                     v_in;
    logic [CHUNK-1:0]         slice_s;
    logic                     slice_c;
    logic                     slice_c_msb;
    logic [(k+1)*CHUNK-1:0]   s_next;
    logic [(k+1)*CHUNK-1:0]   s_q;
    logic                     c_q;
    logic                     valid_q;

    if (k == 0) begin : g_head
      assign a_in   = a;
      assign b_in   = b_eff;
      assign c_in   = c0;
      assign v_in   = in_valid;
      assign s_next = slice_s;
    end else begin : g_body
      assign a_in   = g_stage[k-1].g_skew.a_q;
      assign b_in   = g_stage[k-1].g_skew.b_q;
      assign c_in   = g_stage[k-1].c_q;
      assign v_in   = g_stage[k-1].valid_q;
      // Lower slices ride along so all slices of an op emerge together.
      assign s_next = {slice_s, g_stage[k-1].s_q};
    end

    addsub_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a        (a_in[CHUNK-1:0]),
      .b        (b_in[CHUNK-1:0]),
      .cin      (c_in),
      .s        (slice_s),
      .cout     (slice_c),
      .c_msb_in (slice_c_msb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        c_q     <= 1'b0;
        s_q     <= '0;
      end else if (adv) begin
        valid_q <= v_in;
        c_q     <= slice_c;
        s_q     <= s_next;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [WIn-CHUNK-1:0] a_q;
      logic [WIn-CHUNK-1:0] b_q;
      logic                 unused_c_msb;

      assign unused_c_msb = slice_c_msb;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[WIn-1:CHUNK];
          b_q <= b_in[WIn-1:CHUNK];
        end
      end
    end else begin : g_last
      logic ovf_q;
      logic zero_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q  <= slice_c ^ slice_c_msb;
          zero_q <= (s_next == '0);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign s         = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;
  assign zero      = g_stage[STAGES-1].g_last.zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed self-checking bench for pipelined_addsub at WIDTH=16, CHUNK=4.
module tb_pipelined_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        cout;
  logic        ovf;
  logic        zero;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  vec_t tbl[8];

  pipelined_addsub #(
    .WIDTH (16),
    .CHUNK (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vcin, input logic vsub, input logic [15:0] es,
                         input logic ec, input logic ev, input logic ez);
    int lat;
    a         = va;
    b         = vb;
    cin       = vcin;
    sub       = vsub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    a        = 16'hDEAD;
    b        = 16'hBEEF;
    lat      = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd4);
    check({tag, ".s"}, 32'(s), 32'(es));
    check({tag, ".cout"}, 32'(cout), 32'(ec));
    check({tag, ".ovf"}, 32'(ovf), 32'(ev));
    check({tag, ".zero"}, 32'(zero), 32'(ez));
    tick();
    check({tag, ".no_dup"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int          idx;
    int          oidx;
    int          last_edge;
    int          stale;
    logic        acc;
    logic        drn;
    logic [15:0] hold_s;

    tbl = '{
      '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0},
      '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1},
      '{16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0},
      '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0, 1'b0},
      '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1},
      '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0},
      '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0},
      '{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0}
    };

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    tick();
    tick();
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.s", 32'(s), 32'd0);
    check("reset.flags", 32'({cout, ovf, zero}), 32'd0);
    rst_n = 1'b1;
    tick();

    run_one("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_one("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_one("add_cin", 16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0);
    run_one("add_plain", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    run_one("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_one("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_one("sub_eq", 16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_one("sub_borrow", 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);

    // Back-to-back stream with out_ready dropped for cycles 5..7.
    idx       = 0;
    oidx      = 0;
    last_edge = -1;
    hold_s    = '0;
    for (int cyc = 0; cyc < 40 && oidx < 8; cyc++) begin
      in_valid = (idx < 8);
      if (idx < 8) begin
        a   = tbl[idx].a;
        b   = tbl[idx].b;
        cin = tbl[idx].cin;
        sub = tbl[idx].sub;
      end
      out_ready = !(cyc >= 5 && cyc <= 7);
      #1;
      if (!out_ready) begin
        check("stall.in_ready", 32'(in_ready), 32'd0);
        check("stall.out_valid", 32'(out_valid), 32'd1);
        if (cyc == 5) hold_s = s;
        else check("stall.hold_s", 32'(s), 32'(hold_s));
      end
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      if (drn) begin
        check($sformatf("stream%0d.s", oidx), 32'(s), 32'(tbl[oidx].s));
        check($sformatf("stream%0d.flags", oidx), 32'({cout, ovf, zero}),
              32'({tbl[oidx].c, tbl[oidx].v, tbl[oidx].z}));
        if (oidx == 7) last_edge = cyc;
      end
      tick();
      if (acc) idx++;
      if (drn) oidx++;
    end
    in_valid = 1'b0;
    check("stream.count", 32'(oidx), 32'd8);
    check("stream.last_edge", 32'(last_edge), 32'd14);
    tick();
    check("stream.drained", 32'(out_valid), 32'd0);

    // Fill the pipe under back-pressure, then reset between clock edges.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a        = (i == 0) ? 16'hFFFF : 16'(i);
      b        = 16'hFFFF;
      cin      = 1'b0;
      sub      = 1'b0;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("rst.pre_valid", 32'(out_valid), 32'd1);
    check("rst.pre_s", 32'(s), 32'hFFFE);
    #1 rst_n = 1'b0;
    #1;
    check("rst.async_valid", 32'(out_valid), 32'd0);
    check("rst.async_s", 32'(s), 32'd0);
    check("rst.async_cout", 32'(cout), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    tick();
    run_one("fresh", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    stale     = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) stale++;
      tick();
    end
    check("rst.no_stale", 32'(stale), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
